// File: rtl/apb4_ram_wait.sv
// APB4 scratch RAM with byte strobes, programmable wait states, range/alignment errors and abort.
// Optional secure-region check on PPROT[1] is enabled by defining APB4_RAM_PPROT_EN.
module apb4_ram_wait #(
   parameter int AW          = 16,
   parameter int DW          = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0,
   parameter int SEC_WORDS   = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [AW-1:0]     PADDR,
   input  logic [DW-1:0]     PWDATA,
   input  logic [DW/8-1:0]   PSTRB,
`ifdef APB4_RAM_PPROT_EN
   input  logic [2:0]        PPROT,
`endif
   output logic [DW-1:0]     PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int unsigned NB       = DW / 8;
   localparam int          ADDR_LSB = $clog2(NB);
   localparam int          IW       = AW - ADDR_LSB;
   localparam int          IWP      = IW + 1;
   localparam int          MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << ADDR_LSB) - 1);
   localparam logic [IW:0]   DEPTH_LIM  = IWP'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic              latch, complete;

   logic [AW-1:0]     a_addr;
   logic              a_write;
   logic [DW-1:0]     a_wdata;
   logic [NB-1:0]     a_strb;
   logic              a_nsec;

   logic [IW-1:0]     a_idx;
   logic [MW-1:0]     widx;
   logic              out_of_range, misaligned, sec_violation, err;

   logic [DW-1:0]     mem [DEPTH];

   assign a_idx        = a_addr[AW-1:ADDR_LSB];
   assign widx         = a_idx[MW-1:0];
   assign out_of_range = ({1'b0, a_idx} >= DEPTH_LIM);
   assign misaligned   = |(a_addr & ALIGN_MASK);
`ifdef APB4_RAM_PPROT_EN
   localparam logic [IW:0] SEC_LIM = IWP'(SEC_WORDS);
   assign sec_violation = a_nsec && ({1'b0, a_idx} < SEC_LIM);
`else
   assign sec_violation = 1'b0;
`endif
   assign err = out_of_range | misaligned | sec_violation;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      latch    = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               latch   = 1'b1;
               cnt_n   = 4'(WAIT_CYCLES);
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_n = IDLE;
            end else if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               complete = 1'b1;
               state_n  = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         a_addr  <= '0;
         a_write <= 1'b0;
         a_wdata <= '0;
         a_strb  <= '0;
         a_nsec  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         PREADY  <= complete;
         PSLVERR <= complete && err;
         // PRDATA is zero outside the single response cycle and on any error
         PRDATA  <= (complete && !err && !a_write) ? mem[widx] : '0;
         if (latch) begin
            a_addr  <= PADDR;
            a_write <= PWRITE;
            a_wdata <= PWDATA;
            a_strb  <= PSTRB;
`ifdef APB4_RAM_PPROT_EN
            a_nsec  <= PPROT[1];
`else
            a_nsec  <= 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (complete && a_write && !err) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (a_strb[b]) mem[widx][8*b +: 8] <= a_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb4_ram_wait.sv
// Directed bench for apb4_ram_wait: one instance with no wait states, one with three.
// Define APB4_RAM_PPROT_EN to also exercise the secure-region check.
module tb_apb4_ram_wait;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel0 = 1'b0, sel3 = 1'b0;
   logic        penable = 1'b0, pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [2:0]  pprot = '0;

   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, pslverr0, pslverr3;

   bit          inst = 1'b0;
   logic        rdy, err_m;
   logic [31:0] rdata_m;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rdy     = inst ? pready3  : pready0;
   assign err_m   = inst ? pslverr3 : pslverr0;
   assign rdata_m = inst ? prdata3  : prdata0;

   apb4_ram_wait #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_CYCLES(0), .SEC_WORDS(16)) u0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(sel0), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB4_RAM_PPROT_EN
      .PPROT(pprot),
`endif
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb4_ram_wait #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_CYCLES(3), .SEC_WORDS(16)) u3 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(sel3), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB4_RAM_PPROT_EN
      .PPROT(pprot),
`endif
      .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full transfer: setup, access until PREADY (bounded), then confirm PREADY drops.
   task automatic xfer(input bit i, input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
      inst = i;
      @(negedge clk);
      sel0 = !i; sel3 = i; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         penable = 1'b1;
      end while (!rdy && lat < 30);
      rd = rdata_m;
      er = err_m;
      if (!rdy) chk("timeout", {31'b0, rdy}, 32'd1);
      sel0 = 1'b0; sel3 = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("pready_one_cycle", {31'b0, rdy}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      // Reset state
      #12;
      chk("rst_pready0", {31'b0, pready0}, 32'd0);
      chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
      chk("rst_prdata0", prdata0, 32'd0);
      chk("rst_pready3", {31'b0, pready3}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // 1. zero-wait write/read
      xfer(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, rd, er, lat);
      chk("t1_wr_lat", lat, 32'd2);
      chk("t1_wr_err", {31'b0, er}, 32'd0);
      xfer(1'b0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat);
      chk("t1_rd_lat", lat, 32'd2);
      chk("t1_rd_data", rd, 32'hDEADBEEF);
      chk("t1_rd_err", {31'b0, er}, 32'd0);

      // 2. byte-lane strobes
      xfer(1'b0, 1'b1, 16'h0020, 32'h11223344, 4'hF, rd, er, lat);
      xfer(1'b0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, rd, er, lat);
      xfer(1'b0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, er, lat);
      chk("t2_strb_data", rd, 32'h11BB33DD);

      // PSTRB=0 is a harmless no-op
      xfer(1'b0, 1'b1, 16'h0010, 32'h55555555, 4'h0, rd, er, lat);
      chk("strb0_err", {31'b0, er}, 32'd0);
      xfer(1'b0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat);
      chk("strb0_data", rd, 32'hDEADBEEF);

      // 3. range and alignment errors, plus last legal word
      xfer(1'b0, 1'b0, 16'h1000, 32'h0, 4'h0, rd, er, lat);
      chk("t3_oor_err", {31'b0, er}, 32'd1);
      chk("t3_oor_data", rd, 32'd0);
      xfer(1'b0, 1'b1, 16'h0022, 32'h99999999, 4'hF, rd, er, lat);
      chk("t3_mis_err", {31'b0, er}, 32'd1);
      xfer(1'b0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, er, lat);
      chk("t3_mis_unchanged", rd, 32'h11BB33DD);
      xfer(1'b0, 1'b1, 16'h0FFC, 32'h0BADF00D, 4'hF, rd, er, lat);
      chk("t3_last_wr_err", {31'b0, er}, 32'd0);
      xfer(1'b0, 1'b0, 16'h0FFC, 32'h0, 4'h0, rd, er, lat);
      chk("t3_last_rd", rd, 32'h0BADF00D);

      // PENABLE high in IDLE starts nothing
      inst = 1'b0;
      @(negedge clk); sel0 = 1'b1; penable = 1'b1; paddr = 16'h0010; pwrite = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_enable_ignored", {31'b0, pready0}, 32'd0);
      sel0 = 1'b0; penable = 1'b0;

      // 4. three wait states, then abort
      xfer(1'b1, 1'b1, 16'h0030, 32'h0000CAFE, 4'hF, rd, er, lat);
      chk("t4_wr_lat", lat, 32'd5);
      xfer(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0, rd, er, lat);
      chk("t4_rd_lat", lat, 32'd5);
      chk("t4_rd_data", rd, 32'h0000CAFE);
      inst = 1'b1;
      @(negedge clk); sel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030;
      pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); sel3 = 1'b0; penable = 1'b0;
      lat = 0;
      repeat (6) begin
         @(negedge clk);
         if (pready3) lat++;
      end
      chk("t4_abort_no_ready", lat, 32'd0);
      xfer(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0, rd, er, lat);
      chk("t4_abort_unchanged", rd, 32'h0000CAFE);

      // 5. reset during ACCESS of a write
      xfer(1'b1, 1'b1, 16'h0040, 32'h12345678, 4'hF, rd, er, lat);
      inst = 1'b1;
      @(negedge clk); sel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040;
      pwdata = 32'hFFFF0000; pstrb = 4'hF;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("t5_rst_pready", {31'b0, pready3}, 32'd0);
      chk("t5_rst_pslverr", {31'b0, pslverr3}, 32'd0);
      chk("t5_rst_prdata", prdata3, 32'd0);
      sel3 = 1'b0; penable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      xfer(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0, rd, er, lat);
      chk("t5_after_lat", lat, 32'd5);
      chk("t5_word_unchanged", rd, 32'h12345678);

      // Reset while a read response is on the bus clears it at once
      inst = 1'b0;
      @(negedge clk); sel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
      @(negedge clk); penable = 1'b1;
      @(negedge clk);
      chk("rsp_before_rst", prdata0, 32'hDEADBEEF);
      rst_n = 1'b0;
      #1;
      chk("rsp_rst_pready", {31'b0, pready0}, 32'd0);
      chk("rsp_rst_prdata", prdata0, 32'd0);
      sel0 = 1'b0; penable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      xfer(1'b0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat);
      chk("ram_retained", rd, 32'hDEADBEEF);

`ifdef APB4_RAM_PPROT_EN
      // 6. non-secure access to the secure region
      xfer(1'b0, 1'b1, 16'h0000, 32'h01020304, 4'hF, rd, er, lat);
      pprot = 3'b010;
      xfer(1'b0, 1'b1, 16'h0000, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      chk("t6_ns_err", {31'b0, er}, 32'd1);
      xfer(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, lat);
      chk("t6_ns_rd_err", {31'b0, er}, 32'd1);
      chk("t6_ns_rd_data", rd, 32'd0);
      pprot = 3'b000;
      xfer(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, lat);
      chk("t6_unchanged", rd, 32'h01020304);
      xfer(1'b0, 1'b1, 16'h0000, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      chk("t6_sec_err", {31'b0, er}, 32'd0);
      xfer(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, lat);
      chk("t6_sec_data", rd, 32'hA5A5A5A5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
